// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings.
// Optional rotate feature in the top is enabled by defining USR_ROTATE_EN.
package univ_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } usr_mode_e;

endpackage

// File: rtl/usr_bit_cell.sv
// One bit slice of the universal register: 4:1 source mux feeding a D flip-flop
// with synchronous active-high reset.
module usr_bit_cell
    import univ_shift_reg_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  usr_mode_e sel,
    input  logic      shr_src,
    input  logic      shl_src,
    input  logic      load_bit,
    output logic      q
);

    logic q_r;
    logic next_s;

    // Select the next value of this bit from the operating mode.
    always_comb begin
        next_s = q_r;
        case (sel)
            MODE_HOLD: next_s = q_r;
            MODE_SHR:  next_s = shr_src;
            MODE_SHL:  next_s = shl_src;
            MODE_LOAD: next_s = load_bit;
            default:   next_s = q_r;
        endcase
    end

    // Storage flip-flop; reset wins over every mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= 1'b0;
        end else begin
            q_r <= next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register (hold/load/shift right/shift left) with serial
// ports and a saturating shift counter. Define USR_ROTATE_EN to add the rot port.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    usr_mode_e        mode_s;
    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] shr_src_s;
    logic [WIDTH-1:0] shl_src_s;
    logic             ser_r_bit_s;
    logic             ser_l_bit_s;
    logic [CNT_W-1:0] shift_cnt_r;
    logic             done_r;

    assign mode_s = usr_mode_e'(mode);

    // Edge cells take either the serial inputs or, when rotating, the bit leaving the other end.
`ifdef USR_ROTATE_EN
    assign ser_r_bit_s = rot ? q_s[0]       : ser_in_r;
    assign ser_l_bit_s = rot ? q_s[WIDTH-1] : ser_in_l;
`else
    assign ser_r_bit_s = ser_in_r;
    assign ser_l_bit_s = ser_in_l;
`endif

    assign shr_src_s = {ser_r_bit_s, q_s[WIDTH-1:1]};
    assign shl_src_s = {q_s[WIDTH-2:0], ser_l_bit_s};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        usr_bit_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .sel      (mode_s),
            .shr_src  (shr_src_s[i]),
            .shl_src  (shl_src_s[i]),
            .load_bit (data_in[i]),
            .q        (q_s[i])
        );
    end

    // Shift counter saturating at WIDTH, with done registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_cnt_r <= {CNT_W{1'b0}};
            done_r      <= 1'b0;
        end else begin
            case (mode_s)
                MODE_LOAD: begin
                    shift_cnt_r <= {CNT_W{1'b0}};
                    done_r      <= 1'b0;
                end
                MODE_SHR, MODE_SHL: begin
                    if (shift_cnt_r >= CNT_MAX) begin
                        shift_cnt_r <= CNT_MAX;
                    end else begin
                        shift_cnt_r <= shift_cnt_r + CNT_ONE;
                    end
                    done_r <= (shift_cnt_r >= CNT_LAST);
                end
                default: begin
                    shift_cnt_r <= shift_cnt_r;
                    done_r      <= done_r;
                end
            endcase
        end
    end

    assign data_out  = q_s;
    assign ser_out_r = q_s[0];
    assign ser_out_l = q_s[WIDTH-1];
    assign shift_cnt = shift_cnt_r;
    assign done      = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8; rotate steps run
// only when USR_ROTATE_EN is defined.
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic [1:0]       mode;
    logic [WIDTH-1:0] data_in;
    logic             ser_in_r;
    logic             ser_in_l;
`ifdef USR_ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] data_out;
    logic             ser_out_r;
    logic             ser_out_l;
    logic [CNT_W-1:0] shift_cnt;
    logic             done;

    int checks;
    int errors;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .data_in   (data_in),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
`ifdef USR_ROTATE_EN
        .rot       (rot),
`endif
        .data_out  (data_out),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .shift_cnt (shift_cnt),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] d, input logic [3:0] c,
                               input logic dn);
        check({tag, "_data"}, 32'(data_out), 32'(d));
        check({tag, "_cnt"},  32'(shift_cnt), 32'(c));
        check({tag, "_done"}, 32'(done), 32'(dn));
    endtask

    logic [7:0] shr_exp [8];
    logic       sor_exp [8];

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        mode     = 2'b11;
        data_in  = 8'hA5;
        ser_in_r = 1'b0;
        ser_in_l = 1'b0;
`ifdef USR_ROTATE_EN
        rot      = 1'b0;
`endif
        shr_exp = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
        sor_exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // 1: reset beats load
        step();
        check_state("reset", 8'h00, 4'd0, 1'b0);
        rst = 1'b0;

        // 2: load then hold
        step();
        check_state("load_a5", 8'hA5, 4'd0, 1'b0);
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state("hold", 8'hA5, 4'd0, 1'b0);
        end

        // 3: load 81, shift right x8
        mode    = 2'b11;
        data_in = 8'h81;
        step();
        check_state("load_81", 8'h81, 4'd0, 1'b0);
        mode     = 2'b01;
        ser_in_r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("shr_ser_out_r", 32'(ser_out_r), 32'(sor_exp[i]));
            step();
            check_state("shr", shr_exp[i], 4'(i + 1), (i == 7) ? 1'b1 : 1'b0);
        end

        // 4: shift left ones x9, counter already saturated
        mode     = 2'b10;
        ser_in_l = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check("shl_ser_out_l", 32'(ser_out_l), (i == 8) ? 32'd1 : 32'd0);
            step();
            check_state("shl", (i >= 7) ? 8'hFF : 8'((16'd1 << (i + 1)) - 16'd1), 4'd8, 1'b1);
        end

        // 5: load clears done on the same edge; reset mid-stream
        mode    = 2'b11;
        data_in = 8'h3C;
        step();
        check_state("load_3c", 8'h3C, 4'd0, 1'b0);
        mode     = 2'b01;
        ser_in_r = 1'b1;
        step();
        check_state("shr3c_1", 8'h9E, 4'd1, 1'b0);
        mode = 2'b10;
        ser_in_l = 1'b0;
        step();
        check_state("dirchg", 8'h3C, 4'd2, 1'b0);
        mode = 2'b01;
        step();
        check_state("shr3c_3", 8'h9E, 4'd3, 1'b0);
        rst = 1'b1;
        step();
        check_state("rst_mid", 8'h00, 4'd0, 1'b0);
        rst = 1'b0;
        step();
        check_state("post_rst", 8'h80, 4'd1, 1'b0);

`ifdef USR_ROTATE_EN
        // 6: rotate ignores serial inputs
        mode    = 2'b11;
        data_in = 8'h81;
        step();
        rot      = 1'b1;
        mode     = 2'b10;
        ser_in_l = 1'b0;
        step();
        check_state("rotl_1", 8'h03, 4'd1, 1'b0);
        step();
        check_state("rotl_2", 8'h06, 4'd2, 1'b0);
        rot  = 1'b0;
        mode = 2'b11;
        step();
        rot      = 1'b1;
        mode     = 2'b01;
        ser_in_r = 1'b0;
        step();
        check_state("rotr_1", 8'hC0, 4'd1, 1'b0);
        rot = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
